flash_port_arbiter: RTL and testbench
=====================================

// Module: flash_port_arbiter
// PURPOSE
//  Shares one single-port, 1-cycle-latency flash_contents read port between instruction fetch (IF) and data loads (D).
//  Replaces the stall_lw time-slicing with explicit req/gnt/valid handshakes, so fetches and loads pipeline back-to-back.
//  Sits between the core's fetch/LSU front-ends and the flash macro. Returns raw little-endian words; byte swap and sub-word extraction stay in the consumers.
// PARAMETERS
//  ADDR_W        11       flash word-address width (flash = 2^ADDR_W words)
//  FLASH_BYTES   32'h2000 data addresses >= this are out of range for D
//  IF_STARVE_MAX 4        consecutive IF wait cycles before IF is forced to win (>=1)
// PORTS
//  clk       in   1       clock, all state on posedge
//  reset     in   1       asynchronous, active-low reset
//  if_req    in   1       fetch request; hold with if_addr stable until if_gnt
//  if_addr   in   32      fetch byte address (bits [ADDR_W+1:2] used)
//  if_gnt    out  1       fetch accepted this cycle (combinational)
//  if_valid  out  1       one-cycle pulse: if_data holds fetched word
//  if_data   out  32      fetched word, held until next if_valid
//  d_req     in   1       load request; hold with d_addr stable until d_gnt
//  d_addr    in   32      load byte address
//  d_gnt     out  1       load accepted this cycle (combinational)
//  d_valid   out  1       one-cycle pulse: d_data/d_err valid
//  d_data    out  32      loaded word (0 when d_err), held until next d_valid
//  d_err     out  1       load address >= FLASH_BYTES, qualified by d_valid
//  fl_ren    out  1       flash read enable
//  fl_raddr  out  ADDR_W  flash word address
//  fl_rdata  in   32      flash data, valid the cycle after fl_ren
// BEHAVIOUR
//  - Reset (async, reset==0): if_valid, d_valid, d_err = 0; if_data, d_data = 0; starve_cnt = 0; response pipe cleared.
//    In-flight reads are dropped and never return. fl_ren = 0 while reset is asserted.
//  - Grant cycle N: at most one flash grant. fl_ren=1 and fl_raddr = winner addr[ADDR_W+1:2].
//  - Flash data arrives in N+1 and is registered at end of N+1. valid pulses in N+2, so latency is 2 from gnt.
//  - Throughput: one grant per cycle, no bubbles. The 2-stage tag pipe {is_d, err} tracks ownership.
//  - Arbitration, only in-range requests compete for flash:
//      D wins by default.
//      If starve_cnt == IF_STARVE_MAX and if_req, IF wins.
//  - starve_cnt: +1 each cycle if_req && !if_gnt, saturating at IF_STARVE_MAX. Cleared on if_gnt or !if_req.
//  - Out-of-range D (d_addr >= FLASH_BYTES, unsigned 32-bit compare):
//      d_gnt=1 immediately and no flash access.
//      IF may be granted in the same cycle (dual grant).
//      Returns d_valid with d_err=1, d_data=0 at the same 2-cycle latency.
//  - IF addresses are never range-checked; upper bits alias (wrap) into flash.
//  - gnt depends on req, addresses and starve_cnt only, never on valid (no comb loop to requesters).
//  - Requester dropping req before gnt is legal: no access occurs. Changing addr while req is high and ungranted is a protocol error, flagged by bench assertion.
//  - Responses per requester return in grant order; if_valid and d_valid may pulse in the same cycle.
// STRUCTURE
//  - Shared header flash_arb_defs.vh: FLASH_BYTES default, ADDR_W default, tag bit positions.
//  - One sub-module, flash_rsp_pipe: 2-stage tag shift register plus output data/valid registers, async active-low reset.
//  - Top holds the arbitration comb logic and starve_cnt.
//  - flash_contents is instantiated by the parent (program memory), not here.
// TESTING
//  1. Reset mid-flight: if_gnt in cycle 3, reset low in cycle 4 -> no if_valid ever; all outputs 0 during reset.
//  2. IF only, if_addr=0x10,0x14,0x18 on consecutive cycles, fl_rdata = 0xA0+word index:
//     -> if_gnt 3 cycles, if_valid cycles N+2..N+4, data 0xA4,0xA5,0xA6.
//  3. Simultaneous if_req & d_req(0x100) -> d_gnt only.
//     Then with d_req held continuously, if_gnt exactly in 5th cycle (IF_STARVE_MAX=4).
//  4. d_addr=0x2000 with if_req=1 -> d_gnt & if_gnt same cycle, fl_ren for IF only.
//     Two cycles later d_valid=1, d_err=1, d_data=0, and if_valid=1.
//  5. d_addr=0x1FFC (last word) -> fl_raddr=0x7FF, d_err=0.
//     if_addr=0x2004 -> fl_raddr=0x001 (wrap).
//  6. Random req/addr traffic 10k cycles versus a reference model:
//     per-requester in-order data, no lost or duplicate valids, IF wait <= IF_STARVE_MAX+1.

Source files
------------

// File: rtl/flash_port_arbiter_pkg.sv
// flash_port_arbiter_pkg: default geometry/arbitration constants and the response tag carried down the read pipe
package flash_port_arbiter_pkg;
  localparam int unsigned ADDR_W_DEF = 11;
  localparam logic [31:0] FLASH_BYTES_DEF = 32'h2000;
  localparam int unsigned IF_STARVE_MAX_DEF = 4;
  typedef struct packed {
    logic if_v;
    logic d_v;
    logic d_err;
  } tag_t;
endpackage

// File: rtl/flash_port_arbiter_rsp_pipe.sv
// flash_port_arbiter_rsp_pipe: tag stage aligned with flash data, then registered per-requester responses
module flash_port_arbiter_rsp_pipe
  import flash_port_arbiter_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  tag_t        tag_i,
  input  logic [31:0] fl_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_data_o,
  output logic        d_valid_o,
  output logic [31:0] d_data_o,
  output logic        d_err_o
);
  tag_t        tag_q;
  logic        if_valid_q, d_valid_q, d_err_q, d_err_d;
  logic [31:0] if_data_q, if_data_d, d_data_q, d_data_d;
  always_comb begin
    if_data_d = tag_q.if_v ? fl_rdata_i : if_data_q;
    d_data_d  = tag_q.d_v ? (tag_q.d_err ? '0 : fl_rdata_i) : d_data_q;
    d_err_d   = tag_q.d_v ? tag_q.d_err : d_err_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q      <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      d_err_q    <= 1'b0;
      if_data_q  <= '0;
      d_data_q   <= '0;
    end else begin
      tag_q      <= tag_i;
      if_valid_q <= tag_q.if_v;
      d_valid_q  <= tag_q.d_v;
      d_err_q    <= d_err_d;
      if_data_q  <= if_data_d;
      d_data_q   <= d_data_d;
    end
  end
  assign if_valid_o = if_valid_q;
  assign if_data_o  = if_data_q;
  assign d_valid_o  = d_valid_q;
  assign d_data_o   = d_data_q;
  assign d_err_o    = d_err_q;
endmodule

// File: rtl/flash_port_arbiter.sv
// flash_port_arbiter: shares one 1-cycle flash read port between instruction fetch and data loads
module flash_port_arbiter
  import flash_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter logic [31:0] FLASH_BYTES   = FLASH_BYTES_DEF,
  parameter int unsigned IF_STARVE_MAX = IF_STARVE_MAX_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_gnt_o,
  output logic              if_valid_o,
  output logic [31:0]       if_data_o,
  input  logic              d_req_i,
  input  logic [31:0]       d_addr_i,
  output logic              d_gnt_o,
  output logic              d_valid_o,
  output logic [31:0]       d_data_o,
  output logic              d_err_o,
  output logic              fl_ren_o,
  output logic [ADDR_W-1:0] fl_raddr_o,
  input  logic [31:0]       fl_rdata_i
);
  localparam int unsigned SW = $clog2(IF_STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;
  logic          d_oor, d_inr, if_force, d_fl;
  tag_t          tag;
  logic          unused_addr;
  assign unused_addr = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0], d_addr_i[1:0]};
  // Out-of-range loads never touch flash, so they can be granted alongside a fetch
  always_comb begin
    d_oor      = d_req_i && (d_addr_i >= FLASH_BYTES);
    d_inr      = d_req_i && !d_oor;
    if_force   = if_req_i && (starve_q == SW'(IF_STARVE_MAX));
    if_gnt_o   = rst_ni && if_req_i && (!d_inr || if_force);
    d_fl       = rst_ni && d_inr && !if_force;
    d_gnt_o    = d_fl || (rst_ni && d_oor);
    fl_ren_o   = if_gnt_o || d_fl;
    fl_raddr_o = d_fl ? d_addr_i[ADDR_W+1:2] : if_addr_i[ADDR_W+1:2];
    starve_d   = (if_req_i && !if_gnt_o) ? (if_force ? starve_q : starve_q + SW'(1)) : '0;
    tag        = {if_gnt_o, d_gnt_o, d_oor};
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_q <= '0;
    else starve_q <= starve_d;
  end
  flash_port_arbiter_rsp_pipe u_pipe (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .tag_i      (tag),
    .fl_rdata_i (fl_rdata_i),
    .if_valid_o (if_valid_o),
    .if_data_o  (if_data_o),
    .d_valid_o  (d_valid_o),
    .d_data_o   (d_data_o),
    .d_err_o    (d_err_o)
  );
endmodule

// File: tb/tb_flash_port_arbiter.sv
// tb_flash_port_arbiter: directed + random traffic, grant model and response scoreboard
module tb_flash_port_arbiter;
  localparam int MAXW = 4;
  localparam logic [31:0] FB = 32'h2000;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 0, rst_n;
  logic        if_req, d_req, if_gnt, d_gnt, if_valid, d_valid, d_err, fl_ren;
  logic [31:0] if_addr, d_addr, if_data, d_data, fl_rdata;
  logic [10:0] fl_raddr;

  exp_t ifq[$], dq[$];
  int   checks = 0, passes = 0, cyc = 0, w = 0;
  logic if_gs = 0, d_gs = 0, p_ir = 0, p_ig = 0;
  logic [31:0] p_ia = 0;

  flash_port_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_valid_o(if_valid), .if_data_o(if_data),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_gnt_o(d_gnt), .d_valid_o(d_valid), .d_data_o(d_data), .d_err_o(d_err),
    .fl_ren_o(fl_ren), .fl_raddr_o(fl_raddr), .fl_rdata_i(fl_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fmem(input logic [10:0] a);
    return 32'hA0 + {21'b0, a};
  endfunction

  always @(posedge clk) if (fl_ren) fl_rdata <= fmem(fl_raddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Grant model from the arbitration rules, and scoreboard push on every grant
  always @(negedge clk) begin
    logic inr, oor, e_if, e_d, e_ren;
    if (!rst_n) begin
      chk("rst_if_valid", if_valid, 0);
      chk("rst_d_valid", d_valid, 0);
      chk("rst_d_err", d_err, 0);
      chk("rst_if_data", if_data, 0);
      chk("rst_d_data", d_data, 0);
      chk("rst_fl_ren", fl_ren, 0);
      w = 0;
    end else begin
      if (p_ir && !p_ig && if_req && if_addr != p_ia) $error("protocol: if_addr changed while pending");
      inr   = d_req && (d_addr < FB);
      oor   = d_req && !inr;
      e_if  = if_req && (!inr || w == MAXW);
      e_d   = oor || (inr && !(if_req && w == MAXW));
      e_ren = e_if || (e_d && inr);
      chk("if_gnt", if_gnt, e_if);
      chk("d_gnt", d_gnt, e_d);
      chk("fl_ren", fl_ren, e_ren);
      if (e_ren) chk("fl_raddr", fl_raddr, (e_d && inr) ? d_addr[12:2] : if_addr[12:2]);
      if (if_gnt) begin
        chk("if_wait_bound", w <= MAXW, 1);
        ifq.push_back('{cyc + 2, fmem(if_addr[12:2]), 1'b0});
      end
      if (d_gnt) dq.push_back('{cyc + 2, oor ? 32'h0 : fmem(d_addr[12:2]), oor});
      w = (if_req && !if_gnt) ? w + 1 : 0;
    end
    if_gs = if_gnt; d_gs = d_gnt;
    p_ir = if_req; p_ig = if_gnt; p_ia = if_addr;
  end

  // Response monitor
  always @(negedge clk) if (rst_n) begin
    exp_t e;
    if (if_valid) begin
      if (ifq.size() == 0) chk("if_spurious_valid", 1, 0);
      else begin
        e = ifq.pop_front();
        chk("if_latency", cyc, e.cyc);
        chk("if_data", if_data, e.data);
      end
    end
    if (d_valid) begin
      if (dq.size() == 0) chk("d_spurious_valid", 1, 0);
      else begin
        e = dq.pop_front();
        chk("d_latency", cyc, e.cyc);
        chk("d_data", d_data, e.data);
        chk("d_err", d_err, e.err);
      end
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da);
    @(posedge clk); #1;
    if_req = ir; if_addr = ia; d_req = dr; d_addr = da;
  endtask

  initial begin
    int first;
    rst_n = 0; if_req = 1; if_addr = 32'h30; d_req = 0; d_addr = 0;
    repeat (2) @(posedge clk);
    #1 if_req = 0;
    @(posedge clk); #1 rst_n = 1;
    // reset mid-flight
    drive(0, 0, 0, 0);
    drive(1, 32'h30, 0, 0);
    @(posedge clk); #1;
    rst_n = 0; if_req = 0;
    ifq.delete(); dq.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (4) drive(0, 0, 0, 0);
    // IF back-to-back
    drive(1, 32'h10, 0, 0);
    drive(1, 32'h14, 0, 0);
    drive(1, 32'h18, 0, 0);
    repeat (3) drive(0, 0, 0, 0);
    // starvation
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      drive(1, 32'h20, 1, 32'h100);
      #1;
      if (k == 1) begin
        chk("simul_d_gnt", d_gnt, 1);
        chk("simul_if_gnt", if_gnt, 0);
      end
      if (if_gnt) begin first = k; break; end
    end
    chk("if_starve_win_cycle", first, 5);
    drive(0, 0, 1, 32'h100);
    repeat (3) drive(0, 0, 0, 0);
    // out-of-range load with dual grant
    drive(1, 32'h40, 1, 32'h2000);
    #1;
    chk("oor_d_gnt", d_gnt, 1);
    chk("oor_if_gnt", if_gnt, 1);
    chk("oor_fl_ren", fl_ren, 1);
    chk("oor_fl_raddr", fl_raddr, 32'h10);
    repeat (3) drive(0, 0, 0, 0);
    // boundaries
    drive(0, 0, 1, 32'h1FFC);
    #1 chk("last_word_raddr", fl_raddr, 32'h7FF);
    drive(1, 32'h2004, 0, 0);
    #1 chk("if_wrap_raddr", fl_raddr, 32'h1);
    repeat (3) drive(0, 0, 0, 0);
    // random traffic
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      if (!if_req || if_gs) begin
        if_req = $urandom_range(0, 3) != 0;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom_range(0, 15) == 0) if_req = 0;
      if (!d_req || d_gs) begin
        d_req = $urandom_range(0, 3) != 0;
        case ($urandom_range(0, 9))
          0: d_addr = 32'h1FFC;
          1: d_addr = 32'h2000;
          2, 3: d_addr = $urandom & 32'hFFFF_FFFC;
          default: d_addr = $urandom_range(0, 32'h1FFF) & 32'hFFFF_FFFC;
        endcase
      end else if ($urandom_range(0, 15) == 0) d_req = 0;
    end
    repeat (6) drive(0, 0, 0, 0);
    chk("if_queue_drained", ifq.size(), 0);
    chk("d_queue_drained", dq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
